// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response bus between the fetch stage
// (master) and the instruction memory (slave). One request outstanding at a time.
interface fetch_unit_if #(
   parameter int unsigned PC_W  = 9,
   parameter int unsigned INS_W = 32
);
   logic             imem_req;
   logic [PC_W-1:0]  imem_addr;
   logic             imem_ready;
   logic             imem_rvalid;
   logic [INS_W-1:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rvalid,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Holds the PC, issues one instruction-memory
// request at a time and delivers instructions through a registered IF/ID slot with
// stall, flush and branch-redirect control.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (sticky misaligned-redirect flag).
module fetch_unit #(
   parameter int unsigned PC_W  = 9,
   parameter int unsigned INS_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              PcSel,
   input  logic [31:0]       BrPC,
   fetch_unit_if.master      imem,
   output logic              if_valid,
   output logic [PC_W-1:0]   if_pc,
   output logic [INS_W-1:0]  if_instr,
   output logic              fetch_misalign
);

   typedef enum logic [1:0] {StFetch, StWait, StHold} state_e;

   state_e           state_q;
   logic [PC_W-1:0]  pc_q;
   logic [PC_W-1:0]  req_pc_q;
   logic             drop_q;
   logic [PC_W-1:0]  hb_pc_q;
   logic [INS_W-1:0] hb_instr_q;
   logic             if_valid_q;
   logic [PC_W-1:0]  if_pc_q;
   logic [INS_W-1:0] if_instr_q;

   logic             accept;
   logic             slot_free;
   logic [PC_W-1:0]  br_target;
   logic             unused_br;

   assign br_target = {BrPC[PC_W-1:2], 2'b00};
   assign unused_br = ^{BrPC[31:PC_W], BrPC[1:0]};

   // Moore request: only the state and reset matter, never same-cycle inputs
   assign imem.imem_req  = (state_q == StFetch) && !reset;
   assign imem.imem_addr = pc_q;

   assign accept    = imem.imem_req && imem.imem_ready;
   assign slot_free = !if_valid_q || !stall;

   // FSM, PC, hold buffer and IF/ID slot; a redirect overrides stall and every transition
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StFetch;
         pc_q       <= '0;
         req_pc_q   <= '0;
         drop_q     <= 1'b0;
         hb_pc_q    <= '0;
         hb_instr_q <= '0;
         if_valid_q <= 1'b0;
         if_pc_q    <= '0;
         if_instr_q <= '0;
      end else if (PcSel) begin
         pc_q       <= br_target;
         if_valid_q <= 1'b0;
         unique case (state_q)
            StFetch: begin
               // The stale request still goes out; its response must be dropped
               if (accept) begin
                  state_q  <= StWait;
                  req_pc_q <= pc_q;
                  drop_q   <= 1'b1;
               end
            end
            StWait: begin
               if (imem.imem_rvalid) begin
                  state_q <= StFetch;
                  drop_q  <= 1'b0;
               end else begin
                  drop_q <= 1'b1;
               end
            end
            StHold:  state_q <= StFetch;
            default: state_q <= StFetch;
         endcase
      end else begin
         // Slot is consumed when not stalled; a load below overrides this
         if (!stall) begin
            if_valid_q <= 1'b0;
         end
         unique case (state_q)
            StFetch: begin
               if (accept) begin
                  state_q  <= StWait;
                  req_pc_q <= pc_q;
               end
            end
            StWait: begin
               if (imem.imem_rvalid) begin
                  if (drop_q) begin
                     drop_q  <= 1'b0;
                     state_q <= StFetch;
                  end else if (slot_free) begin
                     if_valid_q <= 1'b1;
                     if_pc_q    <= req_pc_q;
                     if_instr_q <= imem.imem_rdata;
                     pc_q       <= req_pc_q + PC_W'(4);
                     state_q    <= StFetch;
                  end else begin
                     hb_pc_q    <= req_pc_q;
                     hb_instr_q <= imem.imem_rdata;
                     state_q    <= StHold;
                  end
               end
            end
            StHold: begin
               if (!stall) begin
                  if_valid_q <= 1'b1;
                  if_pc_q    <= hb_pc_q;
                  if_instr_q <= hb_instr_q;
                  pc_q       <= hb_pc_q + PC_W'(4);
                  state_q    <= StFetch;
               end
            end
            default: state_q <= StFetch;
         endcase
      end
   end

`ifdef FETCH_MISALIGN_CHECK_EN
   logic misalign_q;

   // Sticky flag: any redirect to a non-word-aligned target, cleared only by reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         misalign_q <= 1'b0;
      end else if (PcSel && (BrPC[1:0] != 2'b00)) begin
         misalign_q <= 1'b1;
      end
   end

   assign fetch_misalign = misalign_q;
`else
   assign fetch_misalign = 1'b0;
`endif

   assign if_valid = if_valid_q;
   assign if_pc    = if_pc_q;
   assign if_instr = if_instr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus a randomized run checked against an
// instruction-stream model (consumed instructions must follow program order,
// restarting at each redirect target).
module tb_fetch_unit;
   localparam int unsigned PC_W  = 9;
   localparam int unsigned INS_W = 32;
`ifdef FETCH_MISALIGN_CHECK_EN
   localparam logic MisalignEn = 1'b1;
`else
   localparam logic MisalignEn = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             stall = 1'b0;
   logic             PcSel = 1'b0;
   logic [31:0]      BrPC = '0;
   logic             if_valid;
   logic [PC_W-1:0]  if_pc;
   logic [INS_W-1:0] if_instr;
   logic             fetch_misalign;

   int n_checks = 0;
   int n_errors = 0;

   // Memory model configuration: latency 0 means random 1..3
   int   mem_lat   = 1;
   bit   rnd_ready = 1'b0;
   logic ready_cfg = 1'b1;

   fetch_unit_if #(.PC_W(PC_W), .INS_W(INS_W)) imem ();

   fetch_unit #(.PC_W(PC_W), .INS_W(INS_W)) dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .PcSel          (PcSel),
      .BrPC           (BrPC),
      .imem           (imem),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_instr       (if_instr),
      .fetch_misalign (fetch_misalign)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [PC_W-1:0] a);
      return {7'h3A, a, 7'h11, a};
   endfunction

   // Instruction memory: accepts on req&&ready, answers once after the latency
   bit              pending = 1'b0;
   int              cnt = 0;
   logic            acc;
   logic [PC_W-1:0] acc_addr, pend_addr;
   initial begin
      imem.imem_ready  = 1'b1;
      imem.imem_rvalid = 1'b0;
      imem.imem_rdata  = '0;
      forever begin
         @(negedge clk);
         acc      = imem.imem_req && imem.imem_ready;
         acc_addr = imem.imem_addr;
         if (imem.imem_req) begin
            n_checks++;
            if (pending || imem.imem_rvalid) begin
               n_errors++;
               $display("FAIL one_outstanding: imem_req=1 while a request is outstanding, required 0");
            end
         end
         @(posedge clk);
         #2;
         if (reset) begin
            pending          = 1'b0;
            imem.imem_rvalid = 1'b0;
         end else begin
            imem.imem_rvalid = 1'b0;
            if (acc) begin
               pending   = 1'b1;
               pend_addr = acc_addr;
               cnt       = (mem_lat == 0) ? int'($urandom_range(1, 3)) : mem_lat;
            end
            if (pending) begin
               cnt--;
               if (cnt == 0) begin
                  imem.imem_rvalid = 1'b1;
                  imem.imem_rdata  = mem_word(pend_addr);
                  pending          = 1'b0;
               end
            end
         end
         imem.imem_ready = rnd_ready ? logic'($urandom_range(0, 99) < 70) : ready_cfg;
      end
   end

   // Leaves the bench in cycle 0: reset just released, #1 after the edge
   task automatic do_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      stall = 1'b0;
      PcSel = 1'b0;
      BrPC  = '0;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      stall = 1'b0;
      PcSel = 1'b0;
      @(negedge clk);
      n_checks++;
      if (if_valid !== 1'b0 || if_pc !== '0 || if_instr !== '0) begin
         n_errors++;
         $display("FAIL reset_slot: got v=%b pc=%h instr=%h, required 0/0/0",
                  if_valid, if_pc, if_instr);
      end
      n_checks++;
      if (imem.imem_req !== 1'b0 || imem.imem_addr !== '0) begin
         n_errors++;
         $display("FAIL reset_req: got req=%b addr=%h, required 0/0",
                  imem.imem_req, imem.imem_addr);
      end
      n_checks++;
      if (fetch_misalign !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_misalign: got %b, required 0", fetch_misalign);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (imem.imem_req !== 1'b1 || imem.imem_addr !== '0) begin
         n_errors++;
         $display("FAIL reset_release_req: got req=%b addr=%h, required 1/000",
                  imem.imem_req, imem.imem_addr);
      end
   endtask

   task automatic test_fetch_loop();
      logic exp_v;
      mem_lat = 1; rnd_ready = 1'b0; ready_cfg = 1'b1;
      do_reset();
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         n_checks++;
         if (imem.imem_req !== logic'(c % 2 == 0)) begin
            n_errors++;
            $display("FAIL loop_req c%0d: got %b, required %b", c, imem.imem_req, c % 2 == 0);
         end
         if (c % 2 == 0) begin
            n_checks++;
            if (imem.imem_addr !== PC_W'(2 * c)) begin
               n_errors++;
               $display("FAIL loop_addr c%0d: got %h, required %h", c, imem.imem_addr, 2 * c);
            end
         end
         exp_v = (c >= 2) && (c % 2 == 0);
         n_checks++;
         if (if_valid !== exp_v) begin
            n_errors++;
            $display("FAIL loop_valid c%0d: got %b, required %b", c, if_valid, exp_v);
         end
         if (exp_v) begin
            n_checks++;
            if (if_pc !== PC_W'(2 * (c - 2)) || if_instr !== mem_word(PC_W'(2 * (c - 2)))) begin
               n_errors++;
               $display("FAIL loop_slot c%0d: got (%h,%h), required (%h,%h)", c, if_pc, if_instr,
                        2 * (c - 2), mem_word(PC_W'(2 * (c - 2))));
            end
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_stall_hold();
      mem_lat = 1; rnd_ready = 1'b0; ready_cfg = 1'b1;
      do_reset();
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         if (c >= 2 && c <= 5) begin
            n_checks++;
            if (if_valid !== 1'b1 || if_pc !== '0 || if_instr !== mem_word('0)) begin
               n_errors++;
               $display("FAIL stall_slot_hold c%0d: got v=%b pc=%h instr=%h, required 1/000/%h",
                        c, if_valid, if_pc, if_instr, mem_word('0));
            end
         end
         if (c >= 3 && c <= 5) begin
            n_checks++;
            if (imem.imem_req !== 1'b0) begin
               n_errors++;
               $display("FAIL stall_no_req c%0d: got req=%b, required 0", c, imem.imem_req);
            end
         end
         if (c == 6) begin
            n_checks++;
            if (if_valid !== 1'b1 || if_pc !== PC_W'(4) || if_instr !== mem_word(PC_W'(4))) begin
               n_errors++;
               $display("FAIL stall_release_slot: got v=%b pc=%h, required 1/004", if_valid, if_pc);
            end
            n_checks++;
            if (imem.imem_req !== 1'b1 || imem.imem_addr !== PC_W'(8)) begin
               n_errors++;
               $display("FAIL stall_resume_addr: got req=%b addr=%h, required 1/008",
                        imem.imem_req, imem.imem_addr);
            end
         end
         @(posedge clk);
         #1;
         stall = (c + 1 >= 2) && (c + 1 <= 4);
      end
      stall = 1'b0;
   endtask

   task automatic test_redirect_wait();
      mem_lat = 2; rnd_ready = 1'b0; ready_cfg = 1'b1;
      do_reset();
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         if (c == 2) begin
            n_checks++;
            if (imem.imem_req !== 1'b0 || imem.imem_addr !== PC_W'(9'h40)) begin
               n_errors++;
               $display("FAIL redir_wait_addr: got req=%b addr=%h, required 0/040",
                        imem.imem_req, imem.imem_addr);
            end
         end
         if (c >= 2 && c <= 5) begin
            n_checks++;
            if (if_valid !== 1'b0) begin
               n_errors++;
               $display("FAIL redir_drop c%0d: got if_valid=%b, required 0", c, if_valid);
            end
         end
         if (c == 3) begin
            n_checks++;
            if (imem.imem_req !== 1'b1 || imem.imem_addr !== PC_W'(9'h40)) begin
               n_errors++;
               $display("FAIL redir_next_req: got req=%b addr=%h, required 1/040",
                        imem.imem_req, imem.imem_addr);
            end
         end
         if (c == 6) begin
            n_checks++;
            if (if_valid !== 1'b1 || if_pc !== PC_W'(9'h40) || if_instr !== mem_word(9'h40)) begin
               n_errors++;
               $display("FAIL redir_first_slot: got v=%b pc=%h instr=%h, required 1/040/%h",
                        if_valid, if_pc, if_instr, mem_word(9'h40));
            end
         end
         @(posedge clk);
         #1;
         PcSel = (c + 1 == 1);
         BrPC  = 32'h40;
      end
      PcSel = 1'b0;
   endtask

   task automatic test_flush_stall();
      mem_lat = 1; rnd_ready = 1'b0; ready_cfg = 1'b1;
      do_reset();
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         if (c == 2) begin
            n_checks++;
            if (if_valid !== 1'b1 || if_pc !== '0) begin
               n_errors++;
               $display("FAIL flush_pre: got v=%b pc=%h, required 1/000", if_valid, if_pc);
            end
         end
         if (c >= 3 && c <= 5) begin
            n_checks++;
            if (if_valid !== 1'b0) begin
               n_errors++;
               $display("FAIL flush_slot c%0d: got if_valid=%b, required 0", c, if_valid);
            end
         end
         if (c == 3) begin
            n_checks++;
            if (imem.imem_req !== 1'b0 || imem.imem_addr !== PC_W'(9'h80)) begin
               n_errors++;
               $display("FAIL flush_pc: got req=%b addr=%h, required 0/080",
                        imem.imem_req, imem.imem_addr);
            end
         end
         if (c == 4) begin
            n_checks++;
            if (imem.imem_req !== 1'b1 || imem.imem_addr !== PC_W'(9'h80)) begin
               n_errors++;
               $display("FAIL flush_req: got req=%b addr=%h, required 1/080",
                        imem.imem_req, imem.imem_addr);
            end
         end
         if (c == 6) begin
            n_checks++;
            if (if_valid !== 1'b1 || if_pc !== PC_W'(9'h80) || if_instr !== mem_word(9'h80)) begin
               n_errors++;
               $display("FAIL flush_free_slot_load: got v=%b pc=%h, required 1/080", if_valid, if_pc);
            end
         end
         @(posedge clk);
         #1;
         stall = (c + 1 >= 2);
         PcSel = (c + 1 == 2);
         BrPC  = 32'h80;
      end
      stall = 1'b0;
      PcSel = 1'b0;
   endtask

   task automatic test_pc_wrap();
      mem_lat = 1; rnd_ready = 1'b0; ready_cfg = 1'b0;
      do_reset();
      PcSel = 1'b1;
      BrPC  = 32'h1FC;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (c == 0 || c == 1) begin
            n_checks++;
            if (imem.imem_req !== 1'b1 || imem.imem_addr !== ((c == 0) ? PC_W'(0) : PC_W'(9'h1FC)))
            begin
               n_errors++;
               $display("FAIL wrap_addr c%0d: got req=%b addr=%h", c, imem.imem_req, imem.imem_addr);
            end
         end
         if (c == 3) begin
            n_checks++;
            if (if_valid !== 1'b1 || if_pc !== PC_W'(9'h1FC) || if_instr !== mem_word(9'h1FC)) begin
               n_errors++;
               $display("FAIL wrap_slot: got v=%b pc=%h, required 1/1fc", if_valid, if_pc);
            end
            n_checks++;
            if (imem.imem_req !== 1'b1 || imem.imem_addr !== '0) begin
               n_errors++;
               $display("FAIL wrap_next_addr: got req=%b addr=%h, required 1/000",
                        imem.imem_req, imem.imem_addr);
            end
         end
         if (c == 5) begin
            n_checks++;
            if (if_valid !== 1'b1 || if_pc !== '0 || if_instr !== mem_word('0)) begin
               n_errors++;
               $display("FAIL wrap_after_slot: got v=%b pc=%h, required 1/000", if_valid, if_pc);
            end
         end
         @(posedge clk);
         #1;
         PcSel     = 1'b0;
         ready_cfg = 1'b1;
      end
   endtask

   task automatic test_misalign();
      mem_lat = 1; rnd_ready = 1'b0; ready_cfg = 1'b0;
      do_reset();
      PcSel = 1'b1;
      BrPC  = 32'h42;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         n_checks++;
         if (fetch_misalign !== ((c == 0) ? 1'b0 : MisalignEn)) begin
            n_errors++;
            $display("FAIL misalign_flag c%0d: got %b, required %b", c, fetch_misalign,
                     (c == 0) ? 1'b0 : MisalignEn);
         end
         if (c == 1) begin
            n_checks++;
            if (imem.imem_req !== 1'b1 || imem.imem_addr !== PC_W'(9'h40)) begin
               n_errors++;
               $display("FAIL misalign_addr: got req=%b addr=%h, required 1/040",
                        imem.imem_req, imem.imem_addr);
            end
         end
         @(posedge clk);
         #1;
         PcSel     = 1'b0;
         ready_cfg = 1'b1;
      end
   endtask

   task automatic test_random();
      logic [PC_W-1:0]  exp_pc = '0;
      logic             exp_mis = 1'b0;
      logic             prev_sel = 1'b0;
      logic             prev_hold = 1'b0;
      logic [PC_W-1:0]  prev_pc = '0;
      logic [INS_W-1:0] prev_instr = '0;
      int               consumed = 0;
      mem_lat = 0; rnd_ready = 1'b1; ready_cfg = 1'b1;
      do_reset();
      for (int cyc = 0; cyc < 2000; cyc++) begin
         @(negedge clk);
         if (prev_sel) begin
            n_checks++;
            if (if_valid !== 1'b0) begin
               n_errors++;
               $display("FAIL rnd_flush cyc%0d: got if_valid=%b, required 0", cyc, if_valid);
            end
         end else if (prev_hold) begin
            n_checks++;
            if (if_valid !== 1'b1 || if_pc !== prev_pc || if_instr !== prev_instr) begin
               n_errors++;
               $display("FAIL rnd_hold cyc%0d: got v=%b pc=%h, required 1/%h",
                        cyc, if_valid, if_pc, prev_pc);
            end
         end
         if (if_valid === 1'b1) begin
            n_checks++;
            if (if_instr !== mem_word(if_pc)) begin
               n_errors++;
               $display("FAIL rnd_data cyc%0d: got %h, required %h", cyc, if_instr, mem_word(if_pc));
            end
            if (!stall && !PcSel) begin
               n_checks++;
               if (if_pc !== exp_pc) begin
                  n_errors++;
                  $display("FAIL rnd_order cyc%0d: got pc=%h, required %h", cyc, if_pc, exp_pc);
               end
               exp_pc = exp_pc + PC_W'(4);
               consumed++;
            end
         end
         n_checks++;
         if (fetch_misalign !== exp_mis) begin
            n_errors++;
            $display("FAIL rnd_misalign cyc%0d: got %b, required %b", cyc, fetch_misalign, exp_mis);
         end
         prev_sel   = PcSel;
         prev_hold  = if_valid && stall && !PcSel;
         prev_pc    = if_pc;
         prev_instr = if_instr;
         if (PcSel) begin
            exp_pc = BrPC[PC_W-1:0] & PC_W'(9'h1FC);
            if (MisalignEn && BrPC[1:0] != 2'b00) exp_mis = 1'b1;
         end
         @(posedge clk);
         #1;
         stall = ($urandom_range(0, 99) < 30);
         PcSel = ($urandom_range(0, 99) < 5);
         BrPC  = $urandom();
      end
      stall = 1'b0;
      PcSel = 1'b0;
      n_checks++;
      if (consumed < 50) begin
         n_errors++;
         $display("FAIL rnd_progress: got %0d instructions consumed, required at least 50", consumed);
      end
      rnd_ready = 1'b0; mem_lat = 1; ready_cfg = 1'b1;
   endtask

   initial begin
      test_reset();
      test_fetch_loop();
      test_stall_hold();
      test_redirect_wait();
      test_flush_stall();
      test_pc_wrap();
      test_misalign();
      test_random();
      test_reset();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
